// File: rtl/i2c_slave_receiver.sv
// Purpose: write-only I2C target; decodes START/addr/sub-addr/data/STOP and emits register-write strobes.
// Latency: SYNC_STAGES+1 CLOCKs from pin to decision; WR_STROBE on the SCL fall that opens the data ACK.
// Backpressure: none; the block never stretches SCL, and every addressed byte is ACKed unconditionally.
module i2c_slave_receiver #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h5D,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic       I2C_SCLK,
    input  logic       I2C_SDAT_IN,
    output logic       I2C_SDAT_OE,
    output logic [7:0] WR_ADDR,
    output logic [7:0] WR_DATA,
    output logic       WR_STROBE,
    output logic       BUSY,
    output logic       END,
    output logic       ACK_ERR
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        SUB,
        SUB_ACK,
        DATA,
        DATA_ACK,
        WAIT_STOP
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_s;
    logic                   sda_s;
    logic                   scl_d;
    logic                   sda_d;
    logic                   scl_rise;
    logic                   scl_fall;
    logic                   start_det;
    logic                   stop_det;

    state_t      state_q;
    state_t      state_d;
    logic [2:0]  bit_cnt_q;
    logic [2:0]  bit_cnt_d;
    logic [7:0]  shreg_q;
    logic [7:0]  shreg_d;
    logic [7:0]  shifted;
    logic        ack_ph_q;
    logic        ack_ph_d;
    logic        oe_q;
    logic        oe_d;
    logic [7:0]  wr_addr_q;
    logic [7:0]  wr_addr_d;
    logic [7:0]  wr_data_q;
    logic [7:0]  wr_data_d;
    logic        strobe_q;
    logic        strobe_d;
    logic        busy_q;
    logic        busy_d;
    logic        end_q;
    logic        end_d;
    logic        ack_err_q;
    logic        ack_err_d;
    logic        seen_q;
    logic        seen_d;

    // Synchronizers reset to the idle-bus level so release of reset never looks like an edge.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], I2C_SCLK};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], I2C_SDAT_IN};
            scl_d    <= scl_s;
            sda_d    <= sda_s;
        end
    end

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    // SCL must be high on both samples so an SCL edge never masquerades as START/STOP.
    assign start_det = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;
    assign shifted   = {shreg_q[6:0], sda_s};

    // Frame decoder: next state plus every registered output; START/STOP take priority.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        ack_ph_d  = ack_ph_q;
        oe_d      = oe_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        strobe_d  = 1'b0;
        busy_d    = busy_q;
        end_d     = 1'b0;
        ack_err_d = ack_err_q;
        seen_d    = seen_q;

        if (start_det) begin
            state_d   = ADDR;
            bit_cnt_d = 3'd0;
            ack_ph_d  = 1'b0;
            oe_d      = 1'b0;
            busy_d    = 1'b0;
            ack_err_d = 1'b0;
            seen_d    = 1'b0;
        end else if (stop_det) begin
            state_d   = IDLE;
            bit_cnt_d = 3'd0;
            ack_phase_reset();
            oe_d      = 1'b0;
            busy_d    = 1'b0;
            end_d     = seen_q;
            seen_d    = 1'b0;
        end else begin
            case (state_q)
                ADDR: begin
                    if (scl_rise) begin
                        shreg_d   = shifted;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if ((shifted[7:1] == SLAVE_ADDR) && !shifted[0]) begin
                                state_d = ADDR_ACK;
                                busy_d  = 1'b1;
                            end else begin
                                state_d   = WAIT_STOP;
                                ack_err_d = 1'b1;
                            end
                        end
                    end
                end
                SUB: begin
                    if (scl_rise) begin
                        shreg_d   = shifted;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            wr_addr_d = shifted;
                            state_d   = SUB_ACK;
                        end
                    end
                end
                DATA: begin
                    if (scl_rise) begin
                        shreg_d   = shifted;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = DATA_ACK;
                        end
                    end
                end
                ADDR_ACK, SUB_ACK, DATA_ACK: begin
                    // First SCL fall drives the ACK low, the second releases it.
                    if (scl_fall) begin
                        if (!ack_ph_q) begin
                            oe_d     = 1'b1;
                            ack_ph_d = 1'b1;
                            if (state_q == DATA_ACK) begin
                                wr_data_d = shreg_q;
                                strobe_d  = 1'b1;
                                seen_d    = 1'b1;
                            end
                        end else begin
                            oe_d     = 1'b0;
                            ack_ph_d = 1'b0;
                            if (state_q == ADDR_ACK) begin
                                state_d = SUB;
                            end else begin
                                state_d = DATA;
                            end
                            if (state_q == DATA_ACK) begin
                                wr_addr_d = wr_addr_q + 8'd1;
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Helper keeps the STOP branch readable; it only clears the ACK sub-phase.
    function automatic void ack_phase_reset();
        ack_ph_d = 1'b0;
    endfunction

    // State and output registers; async reset drops OE the moment RESET falls.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= IDLE;
            bit_cnt_q <= 3'd0;
            shreg_q   <= 8'd0;
            ack_ph_q  <= 1'b0;
            oe_q      <= 1'b0;
            wr_addr_q <= 8'd0;
            wr_data_q <= 8'd0;
            strobe_q  <= 1'b0;
            busy_q    <= 1'b0;
            end_q     <= 1'b0;
            ack_err_q <= 1'b0;
            seen_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            ack_ph_q  <= ack_ph_d;
            oe_q      <= oe_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            strobe_q  <= strobe_d;
            busy_q    <= busy_d;
            end_q     <= end_d;
            ack_err_q <= ack_err_d;
            seen_q    <= seen_d;
        end
    end

    assign I2C_SDAT_OE = oe_q;
    assign WR_ADDR     = wr_addr_q;
    assign WR_DATA     = wr_data_q;
    assign WR_STROBE   = strobe_q;
    assign BUSY        = busy_q;
    assign END         = end_q;
    assign ACK_ERR     = ack_err_q;

endmodule

// File: tb/tb_i2c_slave_receiver.sv
// Purpose: bit-banged I2C master driving the write-only receiver, with a write scoreboard.
// Latency: master quarter-bit is Q CLOCKs (SCL = 16 CLOCKs), well above sync latency.
// Backpressure: none; the bus model is open-drain (line low if master or DUT pulls).
module tb_i2c_slave_receiver;

    localparam int Q = 4;

    logic       CLOCK = 1'b0;
    logic       RESET = 1'b0;
    logic       scl = 1'b1;
    logic       sda_drv = 1'b1;
    logic       sda_line;
    logic       oe;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_strobe;
    logic       busy;
    logic       end_p;
    logic       ack_err;

    int errors = 0;
    int checks = 0;
    int end_cnt = 0;
    int oe_rise = 0;
    logic oe_prev = 1'b0;

    logic [15:0] exp_q[$];
    logic [15:0] obs_q[$];

    typedef struct {
        int          n;
        logic [39:0] b;
        logic [4:0]  acks;
        logic        err;
        int          ends;
    } vec_t;

    vec_t vecs[5];

    assign sda_line = sda_drv & ~oe;

    i2c_slave_receiver #(.SLAVE_ADDR(7'h5D), .SYNC_STAGES(2)) dut (
        .CLOCK       (CLOCK),
        .RESET       (RESET),
        .I2C_SCLK    (scl),
        .I2C_SDAT_IN (sda_line),
        .I2C_SDAT_OE (oe),
        .WR_ADDR     (wr_addr),
        .WR_DATA     (wr_data),
        .WR_STROBE   (wr_strobe),
        .BUSY        (busy),
        .END         (end_p),
        .ACK_ERR     (ack_err)
    );

    always #5 CLOCK = ~CLOCK;

    // Observe DUT events away from the active edge.
    always @(negedge CLOCK) begin
        if (wr_strobe) obs_q.push_back({wr_addr, wr_data});
        if (end_p) end_cnt <= end_cnt + 1;
        if (oe && !oe_prev) oe_rise <= oe_rise + 1;
        oe_prev <= oe;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(int n, logic [39:0] b, logic [4:0] acks, logic err, int ends);
        vec_t v;
        v.n = n; v.b = b; v.acks = acks; v.err = err; v.ends = ends;
        return v;
    endfunction

    task automatic tick(int n);
        repeat (n) @(posedge CLOCK);
        #1;
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic i2c_start();
        sda_drv = 1'b1; tick(Q);
        scl = 1'b1;     tick(Q);
        sda_drv = 1'b0; tick(Q);
        scl = 1'b0;     tick(Q);
    endtask

    task automatic i2c_stop();
        sda_drv = 1'b0; tick(Q);
        scl = 1'b1;     tick(Q);
        sda_drv = 1'b1; tick(2 * Q);
    endtask

    task automatic send_bit(logic b);
        sda_drv = b; tick(Q);
        scl = 1'b1;  tick(2 * Q);
        scl = 1'b0;  tick(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        sda_drv = 1'b1; tick(Q);
        scl = 1'b1;     tick(Q);
        ack = ~sda_line; tick(Q);
        scl = 1'b0;     tick(Q);
    endtask

    task automatic compare_writes(string name);
        logic [15:0] e;
        logic [15:0] o;
        chk({name, "_strobe_count"}, obs_q.size(), exp_q.size());
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            chk({name, "_addr_data"}, o, e);
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic run_vec(int k);
        vec_t        v;
        logic        good;
        logic        ack;
        logic [7:0]  sub;
        logic [7:0]  by;
        int          e0;
        int          o0;
        v    = vecs[k];
        good = (v.b[7:0] == 8'hBA);
        sub  = v.b[15:8];
        for (int i = 2; i < v.n; i++) begin
            by = v.b[8*i +: 8];
            if (good) exp_q.push_back({sub + 8'(i - 2), by});
        end
        e0 = end_cnt;
        o0 = oe_rise;
        i2c_start();
        chk($sformatf("v%0d_ack_err_after_start", k), ack_err, 1'b0);
        for (int i = 0; i < v.n; i++) begin
            send_byte(v.b[8*i +: 8], ack);
            chk($sformatf("v%0d_ack%0d", k, i), ack, v.acks[i]);
            if (i == 0) chk($sformatf("v%0d_busy", k), busy, good);
        end
        i2c_stop();
        chk($sformatf("v%0d_ack_err", k), ack_err, v.err);
        chk($sformatf("v%0d_end", k), end_cnt - e0, v.ends);
        chk($sformatf("v%0d_oe_pulses", k), oe_rise - o0, $countones(v.acks));
        chk($sformatf("v%0d_busy_idle", k), busy, 1'b0);
        compare_writes($sformatf("v%0d", k));
    endtask

    initial begin
        logic ack;
        int   e0;
        vecs[0] = mk(3, 40'h00_00_A5_12_BA, 5'b00111, 1'b0, 1);
        vecs[1] = mk(1, 40'h00_00_00_00_B8, 5'b00000, 1'b1, 0);
        vecs[2] = mk(5, 40'h33_22_11_FE_BA, 5'b11111, 1'b0, 1);
        vecs[3] = mk(1, 40'h00_00_00_00_BB, 5'b00000, 1'b1, 0);
        vecs[4] = mk(2, 40'h00_00_00_40_BA, 5'b00011, 1'b0, 0);

        tick(3);
        chk("rst_oe", oe, 1'b0);
        chk("rst_wr_addr", wr_addr, 8'h00);
        chk("rst_wr_data", wr_data, 8'h00);
        chk("rst_strobe", wr_strobe, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_end", end_p, 1'b0);
        chk("rst_ack_err", ack_err, 1'b0);
        RESET = 1'b1;
        tick(4);

        for (int k = 0; k < 5; k++) run_vec(k);

        // STOP after four data bits: partial byte dropped.
        e0 = end_cnt;
        i2c_start();
        send_byte(8'hBA, ack);
        send_byte(8'h12, ack);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        i2c_stop();
        chk("partial_end", end_cnt - e0, 0);
        chk("partial_oe", oe, 1'b0);
        chk("partial_busy", busy, 1'b0);
        compare_writes("partial");

        // Repeated START mid-data byte restarts address decode.
        e0 = end_cnt;
        i2c_start();
        send_byte(8'hBA, ack);
        send_byte(8'h12, ack);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        i2c_start();
        chk("rstart_oe", oe, 1'b0);
        send_byte(8'hBA, ack);
        chk("rstart_addr_ack", ack, 1'b1);
        chk("rstart_busy", busy, 1'b1);
        i2c_stop();
        chk("rstart_end", end_cnt - e0, 0);
        chk("rstart_busy_idle", busy, 1'b0);
        compare_writes("rstart");

        // Repeated START after a wrong address clears ACK_ERR.
        i2c_start();
        send_byte(8'hB8, ack);
        chk("rs_err_nack", ack, 1'b0);
        chk("rs_err_set", ack_err, 1'b1);
        i2c_start();
        chk("rs_err_cleared", ack_err, 1'b0);
        send_byte(8'hBA, ack);
        chk("rs_err_ack", ack, 1'b1);
        i2c_stop();

        // Async reset while the address ACK is being driven.
        i2c_start();
        for (int i = 7; i >= 0; i--) send_bit(((8'hBA >> i) & 8'h01) != 8'h00);
        begin
            int n = 0;
            while (!oe && n < 20) begin
                tick(1);
                n++;
            end
        end
        chk("arst_oe_before", oe, 1'b1);
        RESET = 1'b0;
        #1;
        chk("arst_oe_now", oe, 1'b0);
        chk("arst_busy", busy, 1'b0);
        tick(2);
        scl = 1'b1;
        sda_drv = 1'b1;
        tick(2);
        RESET = 1'b1;
        tick(8);
        run_vec(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
